mult_div_unit: RTL and testbench

Multi-cycle multiply/divide unit with HI/LO registers, sitting directly downstream of the general register file in the execute stage. Consumes the two register-file read operands (rs, rt), runs signed/unsigned multiply or divide over a fixed cycle count, and holds results in HI/LO for MFHI/MFLO. Exports a `busy` flag so the controller can stall MD-dependent instructions.

---
 rtl/md_pkg.sv | 35 +++
 rtl/md_compute.sv | 64 ++++++
 rtl/mult_div_unit.sv | 116 +++++++++++
 tb/tb_mult_div_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit:
// opcode encodings, widths, default latencies and result bundle.
package md_pkg;

   localparam int MD_OPW         = 3;
   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

   typedef enum logic [MD_OPW-1:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } md_res_t;

   function automatic logic md_is_mul(input logic [MD_OPW-1:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

   function automatic logic md_is_div(input logic [MD_OPW-1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_signed(input logic [MD_OPW-1:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath: (op, a, b) -> {hi,lo}.
// Signed ops work on magnitudes so one unsigned core serves both.
module md_compute
   import md_pkg::*;
(
   input  logic [MD_OPW-1:0] i_op,
   input  logic [31:0]       i_a,
   input  logic [31:0]       i_b,
   output md_res_t           o_res,
   output logic              o_dz
);

   logic        w_sgn;
   logic        w_a_neg;
   logic        w_b_neg;
   logic        w_dz;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [31:0] w_div_b;
   logic [63:0] w_prod;
   logic [63:0] w_prod_s;
   logic [31:0] w_quo;
   logic [31:0] w_rem;
   logic [31:0] w_quo_s;
   logic [31:0] w_rem_s;

   assign w_sgn   = md_is_signed(i_op);
   assign w_a_neg = w_sgn & i_a[31];
   assign w_b_neg = w_sgn & i_b[31];
   assign w_mag_a = w_a_neg ? (32'd0 - i_a) : i_a;
   assign w_mag_b = w_b_neg ? (32'd0 - i_b) : i_b;

   assign w_prod   = {32'd0, w_mag_a} * {32'd0, w_mag_b};
   assign w_prod_s = (w_a_neg ^ w_b_neg) ? (64'd0 - w_prod) : w_prod;

   // Substitute divisor keeps the divider defined when b is zero
   assign w_dz    = (i_b == 32'd0);
   assign w_div_b = w_dz ? 32'd1 : w_mag_b;
   assign w_quo   = w_mag_a / w_div_b;
   assign w_rem   = w_mag_a % w_div_b;
   assign w_quo_s = (w_a_neg ^ w_b_neg) ? (32'd0 - w_quo) : w_quo;
   assign w_rem_s = w_a_neg ? (32'd0 - w_rem) : w_rem;

   always_comb begin
      o_res = '0;
      o_dz  = 1'b0;
      unique case (1'b1)
         md_is_mul(i_op): begin
            o_res.hi = w_prod_s[63:32];
            o_res.lo = w_prod_s[31:0];
         end
         md_is_div(i_op): begin
            o_res.hi = w_rem_s;
            o_res.lo = w_quo_s;
            o_dz     = w_dz;
         end
         default: begin
            o_res = '0;
            o_dz  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Result is computed at start, held pending, committed after a fixed latency.
module mult_div_unit
   import md_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [MD_OPW-1:0] md_op,
   input  logic [31:0]       src_a,
   input  logic [31:0]       src_b,
   output logic              busy,
   output logic [31:0]       hi,
   output logic [31:0]       lo
);

   localparam int unsigned MAXC =
      (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW = $clog2(MAXC + 1);

   localparam logic [CW-1:0] C_MUL = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] C_DIV = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] C_ONE = CW'(1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]    r_state;
   logic [CW-1:0] r_cnt;
   md_res_t       r_pend;
   logic          r_pend_dz;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;

   logic          w_idle_start;
   logic          w_go_mul;
   logic          w_go_div;
   logic          w_mthi;
   logic          w_mtlo;
   logic          w_commit;
   md_res_t       w_res;
   logic          w_dz;

   md_compute u_comp (
      .i_op  (md_op),
      .i_a   (src_a),
      .i_b   (src_b),
      .o_res (w_res),
      .o_dz  (w_dz)
   );

   // Requests are only honoured from IDLE; the controller stalls otherwise
   assign w_idle_start = start && (r_state == S_IDLE);
   assign w_go_mul     = w_idle_start && md_is_mul(md_op);
   assign w_go_div     = w_idle_start && md_is_div(md_op);
   assign w_mthi       = w_idle_start && (md_op == MD_MTHI);
   assign w_mtlo       = w_idle_start && (md_op == MD_MTLO);
   assign w_commit     = (r_state == S_RUN) && (r_cnt == C_ONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_pend    <= '0;
         r_pend_dz <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_go_mul || w_go_div) begin
                  r_state   <= S_RUN;
                  r_cnt     <= w_go_mul ? C_MUL : C_DIV;
                  r_pend    <= w_res;
                  r_pend_dz <= w_dz;
               end
            end
            S_RUN: begin
               if (w_commit) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt - C_ONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // A zero divisor still occupies the unit but leaves HI/LO untouched
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_commit) begin
         if (!r_pend_dz) begin
            r_hi <= r_pend.hi;
            r_lo <= r_pend.lo;
         end
      end else if (w_mthi) begin
         r_hi <= src_a;
      end else if (w_mtlo) begin
         r_lo <= src_a;
      end
   end

   assign busy = r_state[0];
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit.
// Expected results are queued at issue time and popped on completion.
module tb_mult_div_unit;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int   n_cmp;
   int   n_bad;
   exp_t sb[$];

   mult_div_unit dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .md_op (md_op),
      .src_a (src_a),
      .src_b (src_b),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [2:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t        e;
      longint      sa;
      longint      sb_;
      longint      q;
      longint      r;
      logic [63:0] p;
      sa   = longint'($signed(a));
      sb_  = longint'($signed(b));
      e.hi = '0;
      e.lo = '0;
      e.cyc = 0;
      case (op)
         3'd0: begin
            p = sa * sb_;
            e.hi = p[63:32]; e.lo = p[31:0]; e.cyc = 5;
         end
         3'd1: begin
            p = {32'd0, a} * {32'd0, b};
            e.hi = p[63:32]; e.lo = p[31:0]; e.cyc = 5;
         end
         3'd2: begin
            q = sa / sb_;
            r = sa % sb_;
            e.hi = r[31:0]; e.lo = q[31:0]; e.cyc = 10;
         end
         3'd3: begin
            e.hi = a % b; e.lo = a / b; e.cyc = 10;
         end
         default: e.cyc = 0;
      endcase
      return e;
   endfunction

   // Drives one request and counts busy cycles (bounded)
   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int cyc);
      @(negedge clk);
      start = 1'b1; md_op = op; src_a = a; src_b = b;
      @(negedge clk);
      start = 1'b0; src_a = $urandom; src_b = $urandom;
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; md_op = '0; src_a = '0; src_b = '0;
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
      n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
      reset = 1'b1;
   endtask

   task automatic test_mult;
      logic [2:0]  ops[4] = '{3'd0, 3'd1, 3'd0, 3'd1};
      logic [31:0] as[4]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00010000};
      logic [31:0] bs[4]  = '{32'd5, 32'hFFFFFFFF, 32'h80000000, 32'h00010000};
      logic [31:0] eh[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hC0000000, 32'h00000001};
      logic [31:0] el[4]  = '{32'hFFFFFFF1, 32'h00000001, 32'h80000000, 32'h00000000};
      exp_t e;
      int   cyc;
      for (int i = 0; i < 4; i++) begin
         sb.push_back('{eh[i], el[i], 5});
         issue(ops[i], as[i], bs[i], cyc);
         e = sb.pop_front();
         n_cmp++; if (cyc !== e.cyc) begin n_bad++; $display("FAIL mult%0d_cycles got=%0d exp=%0d", i, cyc, e.cyc); end
         n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL mult%0d_hi got=%h exp=%h", i, hi, e.hi); end
         n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL mult%0d_lo got=%h exp=%h", i, lo, e.lo); end
      end
   endtask

   task automatic test_div;
      logic [2:0]  ops[5] = '{3'd2, 3'd3, 3'd2, 3'd2, 3'd2};
      logic [31:0] as[5]  = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd7, 32'hFFFFFFF9};
      logic [31:0] bs[5]  = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE};
      logic [31:0] eh[5]  = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'd1, 32'hFFFFFFFF};
      logic [31:0] el[5]  = '{32'hFFFFFFFD, 32'd3, 32'h80000000, 32'hFFFFFFFD, 32'd3};
      exp_t e;
      int   cyc;
      for (int i = 0; i < 5; i++) begin
         sb.push_back('{eh[i], el[i], 10});
         issue(ops[i], as[i], bs[i], cyc);
         e = sb.pop_front();
         n_cmp++; if (cyc !== e.cyc) begin n_bad++; $display("FAIL div%0d_cycles got=%0d exp=%0d", i, cyc, e.cyc); end
         n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL div%0d_hi got=%h exp=%h", i, hi, e.hi); end
         n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL div%0d_lo got=%h exp=%h", i, lo, e.lo); end
      end
   endtask

   task automatic test_random;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      exp_t e;
      int   cyc;
      for (int i = 0; i < 8; i++) begin
         op = 3'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         if (i[0]) b = b >> $urandom_range(0, 28);
         if (b == 32'd0) b = 32'd3;
         sb.push_back(model(op, a, b));
         issue(op, a, b, cyc);
         e = sb.pop_front();
         n_cmp++; if (cyc !== e.cyc) begin n_bad++; $display("FAIL rnd%0d_cycles op=%0d got=%0d exp=%0d", i, op, cyc, e.cyc); end
         n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, hi, e.hi); end
         n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, lo, e.lo); end
      end
   endtask

   task automatic test_ignore_busy;
      exp_t e;
      int   cyc;
      sb.push_back(model(3'd0, 32'h7FFFFFFF, 32'd2));
      @(negedge clk);
      start = 1'b1; md_op = 3'd0; src_a = 32'h7FFFFFFF; src_b = 32'd2;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
         cyc++;
         if (cyc == 2) begin start = 1'b1; md_op = 3'd4; src_a = 32'h12345678; end
         if (cyc == 3) begin md_op = 3'd3; src_a = 32'd100; src_b = 32'd7; end
         if (cyc == 4) start = 1'b0;
         @(negedge clk);
      end
      e = sb.pop_front();
      n_cmp++; if (cyc !== e.cyc) begin n_bad++; $display("FAIL ignore_cycles got=%0d exp=%0d", cyc, e.cyc); end
      n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL ignore_hi got=%h exp=%h", hi, e.hi); end
      n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL ignore_lo got=%h exp=%h", lo, e.lo); end
      repeat (3) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_no_queue got=%b exp=0", busy); end
   endtask

   task automatic test_moves;
      logic [31:0] old_hi;
      int cyc;
      old_hi = 32'h0000BEEF;
      issue(3'd4, old_hi, 32'd0, cyc);
      n_cmp++; if (hi !== old_hi) begin n_bad++; $display("FAIL mthi_hi got=%h exp=%h", hi, old_hi); end
      issue(3'd5, 32'hCAFEBABE, 32'd0, cyc);
      n_cmp++; if (cyc !== 0) begin n_bad++; $display("FAIL mtlo_busy got=%0d exp=0", cyc); end
      n_cmp++; if (lo !== 32'hCAFEBABE) begin n_bad++; $display("FAIL mtlo_lo got=%h exp=cafebabe", lo); end
      n_cmp++; if (hi !== old_hi) begin n_bad++; $display("FAIL mtlo_hi got=%h exp=%h", hi, old_hi); end
      issue(3'd6, 32'h11111111, 32'h2, cyc);
      issue(3'd7, 32'h22222222, 32'h3, cyc);
      n_cmp++; if (cyc !== 0) begin n_bad++; $display("FAIL undef_busy got=%0d exp=0", cyc); end
      n_cmp++; if ({hi, lo} !== {old_hi, 32'hCAFEBABE}) begin n_bad++; $display("FAIL undef_hilo got=%h_%h exp=%h_cafebabe", hi, lo, old_hi); end
   endtask

   task automatic test_div_zero;
      int cyc;
      issue(3'd4, 32'd1, 32'd0, cyc);
      issue(3'd5, 32'd2, 32'd0, cyc);
      issue(3'd2, 32'h55, 32'd0, cyc);
      n_cmp++; if (cyc !== 10) begin n_bad++; $display("FAIL divz_cycles got=%0d exp=10", cyc); end
      n_cmp++; if ({hi, lo} !== {32'd1, 32'd2}) begin n_bad++; $display("FAIL divz_hilo got=%h_%h exp=00000001_00000002", hi, lo); end
      issue(3'd3, 32'hFFFF0000, 32'd0, cyc);
      n_cmp++; if (cyc !== 10) begin n_bad++; $display("FAIL divuz_cycles got=%0d exp=10", cyc); end
      n_cmp++; if ({hi, lo} !== {32'd1, 32'd2}) begin n_bad++; $display("FAIL divuz_hilo got=%h_%h exp=00000001_00000002", hi, lo); end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   cyc;
      sb.push_back(model(3'd1, 32'h00000123, 32'h00000456));
      sb.push_back(model(3'd3, 32'd1000, 32'd7));
      @(negedge clk);
      start = 1'b1; md_op = 3'd1; src_a = 32'h123; src_b = 32'h456;
      @(negedge clk);
      start = 1'b0;
      e = sb.pop_front();
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
         cyc++;
         // Sampled on the edge busy falls; must be dropped
         if (cyc == e.cyc) begin start = 1'b1; md_op = 3'd5; src_a = 32'hDEAD0000; end
         @(negedge clk);
      end
      n_cmp++; if (cyc !== e.cyc) begin n_bad++; $display("FAIL b2b_first_cycles got=%0d exp=%0d", cyc, e.cyc); end
      n_cmp++; if ({hi, lo} !== {e.hi, e.lo}) begin n_bad++; $display("FAIL b2b_first_hilo got=%h_%h exp=%h_%h", hi, lo, e.hi, e.lo); end
      md_op = 3'd3; src_a = 32'd1000; src_b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      e = sb.pop_front();
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
      n_cmp++; if (cyc !== e.cyc) begin n_bad++; $display("FAIL b2b_second_cycles got=%0d exp=%0d", cyc, e.cyc); end
      n_cmp++; if ({hi, lo} !== {e.hi, e.lo}) begin n_bad++; $display("FAIL b2b_second_hilo got=%h_%h exp=%h_%h", hi, lo, e.hi, e.lo); end
   endtask

   task automatic test_reset_midrun;
      logic rose;
      @(negedge clk);
      start = 1'b1; md_op = 3'd2; src_a = 32'hFFFFFFF9; src_b = 32'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
      #2 reset = 1'b0;
      #1;
      n_cmp++; if ({busy, hi, lo} !== 65'd0) begin n_bad++; $display("FAIL rstmid_now busy=%b hi=%h lo=%h exp=0", busy, hi, lo); end
      #1 reset = 1'b1;
      rose = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (busy !== 1'b0) rose = 1'b1;
      end
      n_cmp++; if (rose !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_after got=%b exp=0", rose); end
      n_cmp++; if ({hi, lo} !== 64'd0) begin n_bad++; $display("FAIL rstmid_hilo got=%h_%h exp=0", hi, lo); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset;
      test_mult;
      test_div;
      test_random;
      test_ignore_busy;
      test_moves;
      test_div_zero;
      test_back_to_back;
      test_reset_midrun;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
